dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder on the far side of the pipeline memory-stage load/store interface.
- Accepts one request at a time from the core over a valid/ready handshake.
- Applies byte/half/word store masking and load extraction with sign or zero extension, selected by funct3.
- Returns a response after a programmable number of wait states; the core stalls on the handshake.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- WAIT_CYCLES, 1, wait states between request accept and response valid (range 0..15).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access fault: range, illegal funct3, or misaligned.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (rst low, asynchronous):
  - state = IDLE; req_ready = 0 while rst is low; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0.
  - Memory array is not cleared.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch we, addr, wdata, funct3, and go to WAIT with counter = WAIT_CYCLES.
  - If WAIT_CYCLES = 0, go directly to RESP.
- WAIT:
  - req_ready = 0; counter decrements each cycle.
  - When counter reaches 1, the next state is RESP.
  - Total accept-to-rsp_valid latency is WAIT_CYCLES+1 cycles.
- Commit point: load read and store write happen on the clock edge entering RESP.
  - A reset asserted during WAIT aborts the access with no memory write.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are stable until rsp_valid & rsp_ready.
  - On that handshake, return to IDLE. req_ready rises the following cycle (no same-cycle re-accept).
- Address decode:
  - offset = addr - BASE_ADDR; word index = offset[..:2].
  - Range fault if offset >= 4*DEPTH_WORDS.
- Stores (we = 1):
  - sb writes byte lane addr[1:0] with wdata[7:0].
  - sh writes lanes addr[1]*2+{0,1} with wdata[15:0].
  - sw writes the full word.
  - Unwritten lanes are preserved.
  - funct3 100/101/other on a store is a fault.
- Loads (we = 0):
  - lb/lh sign-extend; lbu/lhu zero-extend; lw returns the full word.
  - funct3 011/110/111 is a fault.
- Any fault: no write, rsp_rdata = 0, rsp_err = 1, latency unchanged.
- Loads have no side effects.
- A store followed immediately by a load to the same address returns the new data, since accesses are serialised.
- req_valid while not ready is held off; request fields must stay stable until accepted (core obligation, asserted by the bench).

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN
- Defined:
  - Halfword with addr[0] = 1 is a fault (rsp_err = 1, no write, rdata 0).
  - Word with addr[1:0] != 0 is a fault.
- Undefined:
  - Misaligned accesses are forced to natural alignment (addr[0] cleared for half, addr[1:0] cleared for word) and complete normally with rsp_err = 0.

Test Plan:
- Reset then idle:
  - rst low 3 cycles -> req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - After rst high -> req_ready = 1 next cycle.
- Word store/load, WAIT_CYCLES = 1:
  - sw 32'hDEADBEEF to 0x10 -> rsp_valid exactly 2 cycles after accept, rsp_err = 0.
  - lw 0x10 -> rsp_rdata = 32'hDEADBEEF.
- Byte/half merge and extension:
  - sw 0x0 to 0x20; sb 8'h80 to 0x21; sh 16'hF00D to 0x22.
  - lw 0x20 -> 32'hF00D8000.
  - lb 0x21 -> 32'hFFFFFF80; lbu 0x21 -> 32'h00000080.
  - lh 0x22 -> 32'hFFFFF00D; lhu 0x22 -> 32'h0000F00D.
- Response backpressure:
  - Hold rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata, rsp_err stable; req_ready = 0 throughout.
  - Raise rsp_ready -> IDLE next cycle.
- Faults:
  - lw at BASE_ADDR+4*DEPTH_WORDS -> rsp_err = 1, rdata 0.
  - Store with funct3 = 100 -> rsp_err = 1, memory unchanged.
  - lh at 0x31 with DMEM_MISALIGN_TRAP_EN -> rsp_err = 1.
  - Same lh without the macro -> reads the halfword at 0x30.
- Reset mid-access, WAIT_CYCLES = 4:
  - Accept sw 32'h12345678 to 0x40; pulse rst low in the 2nd wait cycle -> rsp_valid never asserts.
  - Subsequent lw 0x40 -> prior contents.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core <-> data-memory load/store handshake bundle.
// master = core side, slave = responder side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data memory with b/h/w masking, wait states.
// DMEM_MISALIGN_TRAP_EN: misaligned h/w fault instead of aligning.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT =
    33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE, WAIT, RESP
  } state_t;

  state_t state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, commit;
  logic        c_we;
  logic [31:0] c_addr, c_wdata;
  logic [2:0]  c_f3;
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [1:0]  lane, elane;
  logic        is_h, is_w;
  logic        f3_bad, range_bad;
  logic        mis_bad, fault;
  logic [31:0] word, sh, ld, wd;
  logic [3:0]  wm;

  assign bus.req_ready = (state == IDLE) & rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign accept = bus.req_valid & bus.req_ready;
  assign commit = rst & (state_n == RESP) &
                  (state != RESP);

  // next-state and wait counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (accept) begin
        cnt_n   = WC;
        state_n = (WC == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = RESP;
      end
      RESP: if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // request in flight: live bus in IDLE, latched later
  always_comb begin
    c_we    = (state == IDLE) ? bus.req_we : we_q;
    c_addr  = (state == IDLE) ? bus.req_addr : addr_q;
    c_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
    c_f3    = (state == IDLE) ? bus.req_funct3 : f3_q;
  end

  // decode, legality and alignment
  always_comb begin
    off       = c_addr - BASE_ADDR;
    range_bad = {1'b0, off} >= LIMIT;
    idx       = off[AW+1:2];
    lane      = off[1:0];
    is_h      = (c_f3[1:0] == 2'b01);
    is_w      = (c_f3[1:0] == 2'b10);
    f3_bad    = 1'b0;
    unique case (c_f3)
      3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
      3'b100, 3'b101:         f3_bad = c_we;
      default:                f3_bad = 1'b1;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_bad = (is_h & lane[0]) | (is_w & (|lane));
    elane   = lane;
`else
    mis_bad = 1'b0;
    elane   = is_w ? 2'b00 :
              is_h ? {lane[1], 1'b0} : lane;
`endif
    fault = f3_bad | range_bad | mis_bad;
  end

  // load extraction and store lane mask
  always_comb begin
    word = mem[idx];
    sh   = word >> {elane, 3'b000};
    wd   = c_wdata << {elane, 3'b000};
    ld   = word;
    wm   = 4'b0000;
    unique case (c_f3)
      3'b000: ld = {{24{sh[7]}}, sh[7:0]};
      3'b001: ld = {{16{sh[15]}}, sh[15:0]};
      3'b100: ld = {24'b0, sh[7:0]};
      3'b101: ld = {16'b0, sh[15:0]};
      default: ld = word;
    endcase
    unique case (c_f3)
      3'b000: wm = 4'b0001 << elane;
      3'b001: wm = 4'b0011 << elane;
      3'b010: wm = 4'b1111;
      default: wm = 4'b0000;
    endcase
  end

  // store commit on the edge entering RESP
  always_ff @(posedge clk) begin
    if (commit & c_we & ~fault) begin
      for (int i = 0; i < 4; i++) begin
        if (wm[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // state, request latch and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        f3_q    <= bus.req_funct3;
      end
      if (commit) begin
        rdata_q <= (fault | c_we) ? 32'd0 : ld;
        err_q   <= fault;
      end
    end
  end

endmodule
